// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART receiver.
// Holds the receiver FSM encoding and the data byte width.
package servant_uart_pkg;

  localparam int DATA_W = 8;
  localparam int BIT_IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/servant_uart_rx_if.sv
// Byte stream leaving the UART receiver: FIFO head with valid/ready handshake
// plus the one-cycle frame-error and overflow status pulses.
interface servant_uart_rx_if;
  import servant_uart_pkg::*;

  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_frame_err;
  logic              o_overflow;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overflow,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overflow,
    output i_ready
  );

endinterface

// File: rtl/servant_uart_fifo.sv
// First-word-fall-through FIFO for received bytes. Pointers carry one extra
// wrap bit so full and empty are told apart by the MSB compare.
module servant_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Head is presented combinationally; forced to zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/servant_uart_rx.sv
// UART receiver: synchronizes rx, detects and mid-bit samples 8N1 frames,
// and buffers received bytes in a FWFT FIFO with frame-error/overflow pulses.
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic               rx,
  servant_uart_rx_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  // Reset asserts immediately but is released only after two clean edges.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) rst_sync_reg <= 2'b00;
    else           rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n_int = rst_sync_reg[1];

  // Idle-high synchronizer so reset never looks like a start bit edge.
  logic [1:0] rx_sync_reg;
  logic       rx_s;

  always_ff @(posedge wb_clk or negedge rst_n_int) begin
    if (!rst_n_int) rx_sync_reg <= 2'b11;
    else            rx_sync_reg <= {rx_sync_reg[0], rx};
  end

  assign rx_s = rx_sync_reg[1];

  uart_state_e           state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [BIT_IDX_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [DATA_W-1:0]     shift_reg, shift_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  overflow_reg, overflow_next;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cnt_zero;

  always_ff @(posedge wb_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign cnt_zero = (cnt_reg == '0);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    fifo_push      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (!rx_s) begin
          state_next   = DATA;
          cnt_next     = FULL_LOAD;
          bit_idx_next = '0;
        end else begin
          // Line went back high before mid start bit: treat as a glitch.
          state_next = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          shift_next = {rx_s, shift_reg[DATA_W-1:1]};
          cnt_next   = FULL_LOAD;
          if (bit_idx_reg == LAST_BIT) state_next = STOP;
          else                         bit_idx_next = bit_idx_reg + BIT_IDX_W'(1);
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (rx_s) begin
          fifo_push  = 1'b1;
          state_next = IDLE;
        end else begin
          frame_err_next = 1'b1;
          state_next     = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full implies non-empty, so i_ready alone means a pop frees a slot this cycle.
  assign overflow_next = fifo_push && fifo_full && !bus.i_ready;

  servant_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (wb_clk),
    .rst_n     (rst_n_int),
    .push      (fifo_push),
    .push_data (shift_reg),
    .pop       (bus.i_ready),
    .pop_data  (bus.o_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.o_valid     = !fifo_empty;
  assign bus.o_frame_err = frame_err_reg;
  assign bus.o_overflow  = overflow_reg;

endmodule
